// File: rtl/encoder_proj_pkg.sv
// Shared constants, output FSM state type and the Hamming(7,4) helpers for encoder_proj.
package encoder_proj_pkg;

  localparam int DATA_W = 4;
  localparam int CW_W   = 7;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } enc_state_e;

  // Codeword bit i is Hamming position i+1: {d3,d2,d1,p2,d0,p1,p0}
  function automatic logic [CW_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d);
    logic p0;
    logic p1;
    logic p2;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p2, d[0], p1, p0};
  endfunction

  function automatic logic [CW_W-1:0] flip_mask(input logic [2:0] n);
    logic [CW_W-1:0] m;
    if (n == 3'd0) begin
      m = 7'b0000000;
    end else begin
      m = 7'b0000001 << (n - 3'd1);
    end
    return m;
  endfunction

endpackage

// File: rtl/encoder_proj_fifo.sv
// Nibble FIFO for encoder_proj; power-of-two depth, pointers carry one extra wrap bit.
module encoder_proj_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      wptr_d;
  logic [AW:0]      rptr_q;
  logic [AW:0]      rptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset: entries are only ever read after being written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/encoder_proj.sv
// Hamming(7,4) encoder: nibble FIFO feeding a registered valid/ready codeword stage.
// Optional ENC_ERR_INJECT_EN adds err_flip to invert one codeword bit on load.
module encoder_proj
  import encoder_proj_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   io_out,
`ifdef ENC_ERR_INJECT_EN
  input  logic [2:0]        err_flip,
`endif
  output logic [CNT_W-1:0]  sent_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  enc_state_e        state_q;
  logic [CW_W-1:0]   io_out_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              load;
  logic              fire;
  logic [CW_W-1:0]   err_mask;
  logic [CW_W-1:0]   next_cw;

  encoder_proj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (load),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (fifo_head)
  );

`ifdef ENC_ERR_INJECT_EN
  assign err_mask = flip_mask(err_flip);
`else
  assign err_mask = 7'b0000000;
`endif

  // A full FIFO refuses input even when the head is leaving this cycle.
  assign in_ready = !fifo_full;
  assign fire     = (state_q == ST_LOADED) && out_ready;
  assign load     = !fifo_empty && ((state_q == ST_EMPTY) || out_ready);
  assign next_cw  = hamming74_enc(fifo_head) ^ err_mask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      io_out_q    <= 7'b0000000;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            io_out_q    <= next_cw;
            out_valid_q <= 1'b1;
            state_q     <= ST_LOADED;
          end else begin
            state_q     <= ST_EMPTY;
          end
        end
        ST_LOADED: begin
          if (out_ready && load) begin
            io_out_q    <= next_cw;
            out_valid_q <= 1'b1;
            state_q     <= ST_LOADED;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end else begin
            state_q     <= ST_LOADED;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fire && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign io_out     = io_out_q;
  assign out_valid  = out_valid_q;
  assign sent_count = cnt_q;

endmodule

// File: doc/encoder_proj.md
# encoder_proj

Hamming(7,4) encoder that produces the 7-bit codewords consumed on `io_in[6:0]` by `decoder_proj`. It accepts 4-bit data nibbles over a valid/ready handshake, buffers them in a small FIFO, and presents one registered codeword at a time on a valid/ready output. A saturating counter reports how many codewords have been delivered.

## Interface
- `FIFO_DEPTH`, default 4: nibble FIFO depth; power of two, ≥2.
- `CNT_W`, default 16: width of the delivered-codeword counter.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: nibble offered.
- `in_ready` out 1: FIFO can accept; equals `!full`.
- `in_data` in 4: data nibble `d[3:0]`.
- `out_valid` out 1: `io_out` holds a valid codeword.
- `out_ready` in 1: downstream accepts the codeword.
- `io_out` out 7: codeword `{d3,d2,d1,p2,d0,p1,p0}`.
- `sent_count` out CNT_W: count of codewords delivered, saturating.
- `err_flip` in 3: present only with `ENC_ERR_INJECT_EN`.

## Operation
- Parity bits:
  - `p0 = d0^d1^d3`
  - `p1 = d0^d2^d3`
  - `p2 = d1^d2^d3`
  - Bit `i` of `io_out` is Hamming position `i+1`.
- Input transfer: `in_valid && in_ready` on a rising edge pushes `in_data` into the FIFO.
- `in_ready` depends only on FIFO occupancy. A full FIFO drops `in_ready` even if a pop happens in the same cycle; there is no pass-through when full.
- Output stage is a two-state FSM:
  - EMPTY → LOADED when the FIFO is non-empty. The head nibble is popped and its encoded codeword is registered into `io_out`.
  - LOADED with `out_valid && out_ready`: if the FIFO is non-empty, load the next codeword in the same edge and stay LOADED; otherwise go to EMPTY.
  - LOADED without `out_ready`: hold `io_out` stable.
- `io_out` keeps its last value in EMPTY. Do not clear it.
- `sent_count` increments on every output transfer and saturates at `2^CNT_W-1`; no wrap.
- A push and a pop in the same cycle leave occupancy unchanged. FIFO pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-operation: the FIFO is flushed, the FSM goes to EMPTY, and any in-flight codeword is discarded.

## Timing
- Reset values:
  - `out_valid=0`, `io_out=7'b0`, `sent_count=0`.
  - `in_ready=1`, since the FIFO is empty.
  - FSM = EMPTY.
- Latency from an empty pipeline: nibble accepted at edge k → `out_valid=1` with its codeword after edge k+1.
- Throughput: one codeword per cycle when `out_ready` is held high and input is continuous.
- `io_out` and `out_valid` are registered outputs. `in_ready` is combinational from FIFO occupancy only, never from `in_valid` or `out_ready`.
- Once `out_valid` is asserted, it and `io_out` stay stable until the transfer completes.

## Configuration
- `ENC_ERR_INJECT_EN` defined:
  - Port `err_flip[2:0]` exists.
  - When a codeword is loaded into `io_out` and `err_flip=n` with n in 1..7, bit `n-1` of the loaded codeword is inverted.
  - `n=0` means no flip.
  - `err_flip` is sampled only on the load edge.
- `ENC_ERR_INJECT_EN` undefined: the port is absent and codewords are always clean.

## Structure
- Package `encoder_proj_pkg`:
  - Constants `DATA_W=4` and `CW_W=7`.
  - FSM state typedef (`ST_EMPTY`, `ST_LOADED`).
  - Function `hamming74_enc(d)` returning the codeword.
- Sub-module `encoder_proj_fifo`:
  - Parameterized by `FIFO_DEPTH` and width.
  - Ports: push/pop, `full`/`empty`, head data.
  - Same async active-high `reset`.
- `encoder_proj` holds the FSM, output register, error injection and counter.

## Test plan
- Reset then idle → `in_ready=1`, `out_valid=0`, `io_out=0`, `sent_count=0`.
- Push 4'b1011 with `out_ready=1` → `io_out=7'b1010101` and `out_valid=1` one edge after acceptance; `sent_count=1` after the transfer.
- Stream 0x0, 0xF, 0x1 back-to-back with `out_ready=1` → `io_out` = 7'b0000000, 7'b1111111, 7'b0000111 on consecutive cycles.
- Hold `out_ready=0` and push 5 nibbles (DEPTH=4):
  - `in_ready` drops once the FIFO is full (4 in FIFO and 1 in the output register).
  - `io_out` stays stable.
  - Releasing `out_ready` drains all 5 in order.
- Assert `reset` while LOADED with the FIFO full → asynchronously `out_valid=0` and `in_ready=1`; after release, a new nibble yields only its own codeword.
- With `ENC_ERR_INJECT_EN`: push 4'b1011 with `err_flip=3` → `io_out=7'b1010001`. With `err_flip=0` → 7'b1010101.
